seq_step_ctrl: RTL and testbench
================================

SEQ_STEP_CTRL -- requirements
Module: seq_step_ctrl

Interface
REQ-001 Parameter STEP_W, default 8, width of the step-count input and the wrap counter.
REQ-002 Parameter START_STATE, default 3'b100, sequence start/home state.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port clear  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  request a run of step_num steps.
REQ-006 Port pause  input  1  level; freezes stepping while high.
REQ-007 Port abort  input  1  terminates any activity; returns to IDLE.
REQ-008 Port step_num  input  STEP_W  number of steps per run.
REQ-009 Ports wr_en, wr_addr, wr_data  input  1/3/3  next-state table write (table[wr_addr] <= wr_data).
REQ-010 Ports q, qBar  output  3/3  current sequence state and its complement.
REQ-011 Ports busy, done  output  1/1  run in progress; one-cycle completion pulse.
REQ-012 Port wrap_cnt  output  STEP_W  count of returns to START_STATE in the current run.

Function
REQ-013 Contains an 8x3 next-state table and one FSM: IDLE, RUN, PAUSE, DONE.
REQ-014 Table default contents: 4->7, 7->0, 0->5, 5->1, 1->4; unused entries 2, 3 and 6 -> 4.
REQ-015 A table write takes effect only in IDLE or DONE; writes in RUN or PAUSE are silently dropped.
REQ-016 IDLE: q = START_STATE; start with step_num != 0 -> RUN, remaining <= step_num, q unchanged.
REQ-017 IDLE or DONE, start with step_num == 0 -> DONE with done = 1 the next cycle; q <= START_STATE; no step.
REQ-018 RUN, pause low: each edge q <= table[q], remaining <= remaining-1; if remaining == 1, also -> DONE, done <= 1.
REQ-019 done and the final q become visible in the same cycle; done deasserts on the following edge.
REQ-020 Latency: start sampled at edge k; first step at edge k+1; the Nth step at edge k+N.
REQ-021 RUN with pause high -> PAUSE; no step on that edge; pause has priority over stepping.
REQ-022 PAUSE: q and remaining are held; pause low -> RUN; stepping resumes on the next edge.
REQ-023 DONE: q holds the final value; start behaves as in IDLE, but q <= START_STATE on acceptance.
REQ-024 abort in any state -> IDLE; q <= START_STATE; no done pulse; abort has priority over start and pause.
REQ-025 Write and start on the same edge in IDLE: both take effect; the first step uses the new entry.
REQ-026 busy = 1 in RUN or PAUSE, otherwise 0.
REQ-027 qBar = ~q combinationally at all times.

Reset
REQ-028 clear high -> immediately: FSM = IDLE, q = START_STATE, qBar = ~START_STATE, busy = 0, done = 0, wrap_cnt = 0, remaining = 0, table = defaults of REQ-014.
REQ-029 clear mid-run discards the run; no done pulse is produced.
REQ-030 Inputs are ignored while clear is high; the first sampling edge is the one after clear deasserts.

Configuration
REQ-031 Macro SEQ_STEP_CTRL_WRAP_CNT_EN defined: wrap_cnt increments on each RUN step whose new q == START_STATE.
REQ-032 With the macro defined, wrap_cnt clears on start acceptance and saturates at all-ones.
REQ-033 Macro SEQ_STEP_CTRL_WRAP_CNT_EN undefined: wrap_cnt port is present, tied to 0, and no counter logic is built.

Verification
REQ-034 Pulse clear; start, step_num = 5 -> q = 4, 7, 0, 5, 1, 4 on successive edges; done = 1 only with final q = 4; wrap_cnt = 1 (macro on) or 0 (macro off).
REQ-035 step_num = 3; pause high for 2 cycles after the first step -> q = 7 held 2 cycles, then 0, 5; done with q = 5; busy high throughout.
REQ-036 In IDLE write table[4] = 2 and table[2] = 6; start with N = 2 -> q = 2, 6; a write to table[6] during RUN is dropped (rerun after reset-to-IDLE shows q = 6 -> 4).
REQ-037 start with step_num = 0 -> next cycle DONE, done = 1, q = 4, busy never asserted.
REQ-038 abort at step 2 of a 5-step run -> q = 4, IDLE, no done.
REQ-039 clear mid-run -> immediate q = 4, busy = 0, and the table restored to defaults.

Source files
------------

// File: rtl/seq_step_ctrl.sv
// seq_step_ctrl: table-driven 3-bit sequence stepper with run/pause/abort
// control, a writable 8x3 next-state table and an optional wrap counter.
//
// Ports:
//   clk            rising-edge clock
//   clear          asynchronous active-high reset
//   start          request a run of step_num steps (from IDLE or DONE)
//   pause          level; freezes stepping while high during a run
//   abort          return to IDLE from any state, no completion pulse
//   step_num       steps per run (0 completes immediately)
//   wr_en/addr/data next-state table write, accepted only in IDLE/DONE
//   q, qBar        current sequence state and its complement
//   busy           high in RUN or PAUSE
//   done           one-cycle pulse, coincident with the final q
//   wrap_cnt       returns to START_STATE in the current run
//
// Build option: define SEQ_STEP_CTRL_WRAP_CNT_EN to build the wrap counter;
// otherwise wrap_cnt is tied to zero.

module seq_step_ctrl #(
    parameter int         STEP_W      = 8,
    parameter logic [2:0] START_STATE = 3'b100
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    input  logic [STEP_W-1:0] step_num,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [2:0]        wr_data,
    output logic [2:0]        q,
    output logic [2:0]        qBar,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [2:0]        q_q;
    logic [STEP_W-1:0] rem_q;
    logic              busy_q;
    logic              done_q;
    logic [2:0]        tbl_q [8];

    logic [2:0]        q_nxt;
    logic              tbl_open;

    function automatic logic [2:0] tbl_default(input logic [2:0] a);
        logic [2:0] r;
        unique case (a)
            3'd4:    r = 3'd7;
            3'd7:    r = 3'd0;
            3'd0:    r = 3'd5;
            3'd5:    r = 3'd1;
            3'd1:    r = 3'd4;
            default: r = 3'd4;
        endcase
        return r;
    endfunction

    assign q_nxt    = tbl_q[q_q];
    assign tbl_open = (state_q == S_IDLE) || (state_q == S_DONE);

    // Table is frozen while a run is in flight so a run always follows
    // the contents it started with.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 8; i++) begin
                tbl_q[i] <= tbl_default(3'(i));
            end
        end else if (wr_en && tbl_open) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            q_q     <= START_STATE;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                q_q     <= START_STATE;
                rem_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            q_q <= START_STATE;
                            if (step_num == '0) begin
                                state_q <= S_DONE;
                                rem_q   <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                                rem_q   <= step_num;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        // pause wins over stepping on the same edge
                        if (pause) begin
                            state_q <= S_PAUSE;
                        end else begin
                            q_q   <= q_nxt;
                            rem_q <= rem_q - 1'b1;
                            if (rem_q == STEP_W'(1)) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    S_PAUSE: begin
                        // resume edge only re-enters RUN; next edge steps
                        if (!pause) begin
                            state_q <= S_RUN;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign q    = q_q;
    assign qBar = ~q_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef SEQ_STEP_CTRL_WRAP_CNT_EN
    logic [STEP_W-1:0] wrap_q;
    logic              start_acc;
    logic              step_fire;

    assign start_acc = !abort && tbl_open && start;
    assign step_fire = !abort && (state_q == S_RUN) && !pause;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wrap_q <= '0;
        end else if (start_acc) begin
            wrap_q <= '0;
        end else if (step_fire && (q_nxt == START_STATE) &&
                     (wrap_q != '1)) begin
            wrap_q <= wrap_q + 1'b1;
        end
    end

    assign wrap_cnt = wrap_q;
`else
    assign wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Directed testbench for seq_step_ctrl.
// Each task drives one scenario and checks outputs one time unit after edges.

module tb_seq_step_ctrl;

    logic       clk = 1'b0;
    logic       clear;
    logic       start;
    logic       pause;
    logic       abort;
    logic [7:0] step_num;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] wr_data;
    logic [2:0] q;
    logic [2:0] qBar;
    logic       busy;
    logic       done;
    logic [7:0] wrap_cnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SEQ_STEP_CTRL_WRAP_CNT_EN
    localparam int WRAP_ON = 1;
`else
    localparam int WRAP_ON = 0;
`endif

    seq_step_ctrl dut (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .step_num (step_num),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .q        (q),
        .qBar     (qBar),
        .busy     (busy),
        .done     (done),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        wr_en = 1'b0;
        #3;
        clear = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clear = 1'b1;
        start = 1'b1;
        step_num = 8'd3;
        #2;
        n_checks++;
        if (q !== 3'd4 || qBar !== 3'd3 || busy !== 1'b0 ||
            done !== 1'b0 || wrap_cnt !== 8'd0) begin
            $display("FAIL reset_state: got q=%0d qBar=%0d busy=%b done=%b wrap=%0d required q=4 qBar=3 busy=0 done=0 wrap=0",
                     q, qBar, busy, done, wrap_cnt);
            n_fail++;
        end
        tick();
        n_checks++;
        if (q !== 3'd4 || busy !== 1'b0) begin
            $display("FAIL reset_ignores_start: got q=%0d busy=%b required q=4 busy=0",
                     q, busy);
            n_fail++;
        end
        do_clear();
    endtask

    task automatic test_run5();
        logic [2:0] exp_q [6];
        exp_q[0] = 3'd4; exp_q[1] = 3'd7; exp_q[2] = 3'd0;
        exp_q[3] = 3'd5; exp_q[4] = 3'd1; exp_q[5] = 3'd4;
        do_clear();
        start = 1'b1;
        step_num = 8'd5;
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'b0;
            n_checks++;
            if (q !== exp_q[i] || qBar !== ~exp_q[i]) begin
                $display("FAIL run5_q%0d: got q=%0d qBar=%0d required q=%0d",
                         i, q, qBar, exp_q[i]);
                n_fail++;
            end
            n_checks++;
            if (done !== (i == 5) || busy !== (i != 5)) begin
                $display("FAIL run5_flags%0d: got done=%b busy=%b required done=%b busy=%b",
                         i, done, busy, (i == 5), (i != 5));
                n_fail++;
            end
        end
        n_checks++;
        if (wrap_cnt !== 8'(WRAP_ON)) begin
            $display("FAIL run5_wrap: got %0d required %0d", wrap_cnt, WRAP_ON);
            n_fail++;
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || q !== 3'd4) begin
            $display("FAIL run5_after: got done=%b q=%0d required done=0 q=4",
                     done, q);
            n_fail++;
        end
    endtask

    task automatic test_pause();
        logic [2:0] exp_q [7];
        logic       pz [7];
        exp_q[0] = 3'd4; exp_q[1] = 3'd7; exp_q[2] = 3'd7;
        exp_q[3] = 3'd7; exp_q[4] = 3'd7; exp_q[5] = 3'd0;
        exp_q[6] = 3'd5;
        pz[0] = 0; pz[1] = 1; pz[2] = 1; pz[3] = 0;
        pz[4] = 0; pz[5] = 0; pz[6] = 0;
        do_clear();
        start = 1'b1;
        step_num = 8'd3;
        for (int i = 0; i < 7; i++) begin
            tick();
            start = 1'b0;
            pause = pz[i];
            n_checks++;
            if (q !== exp_q[i] || busy !== (i != 6) || done !== (i == 6)) begin
                $display("FAIL pause_c%0d: got q=%0d busy=%b done=%b required q=%0d busy=%b done=%b",
                         i, q, busy, done, exp_q[i], (i != 6), (i == 6));
                n_fail++;
            end
        end
    endtask

    task automatic test_table_write();
        do_clear();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 3'd2;
        tick();
        wr_addr = 3'd2; wr_data = 3'd6;
        tick();
        wr_en = 1'b0;
        start = 1'b1; step_num = 8'd2;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 3'd0;
        tick();
        n_checks++;
        if (q !== 3'd2) begin
            $display("FAIL tbl_step1: got q=%0d required 2", q);
            n_fail++;
        end
        wr_en = 1'b0;
        tick();
        n_checks++;
        if (q !== 3'd6 || done !== 1'b1) begin
            $display("FAIL tbl_step2: got q=%0d done=%b required q=6 done=1",
                     q, done);
            n_fail++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b1; step_num = 8'd3;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (q !== 3'd4 || done !== 1'b1) begin
            $display("FAIL tbl_drop_in_run: got q=%0d done=%b required q=4 done=1",
                     q, done);
            n_fail++;
        end
    endtask

    task automatic test_zero_steps();
        int seen_busy = 0;
        do_clear();
        start = 1'b1; step_num = 8'd0;
        tick();
        start = 1'b0;
        if (busy) seen_busy++;
        n_checks++;
        if (done !== 1'b1 || q !== 3'd4) begin
            $display("FAIL zero_done: got done=%b q=%0d required done=1 q=4",
                     done, q);
            n_fail++;
        end
        tick();
        if (busy) seen_busy++;
        n_checks++;
        if (done !== 1'b0 || seen_busy != 0) begin
            $display("FAIL zero_after: got done=%b busy_cycles=%0d required done=0 busy_cycles=0",
                     done, seen_busy);
            n_fail++;
        end
    endtask

    task automatic test_abort();
        int seen_done = 0;
        do_clear();
        start = 1'b1; step_num = 8'd5;
        tick();
        start = 1'b0;
        tick(); tick();
        n_checks++;
        if (q !== 3'd0) begin
            $display("FAIL abort_pre: got q=%0d required 0", q);
            n_fail++;
        end
        abort = 1'b1; start = 1'b1; pause = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0; pause = 1'b0;
        if (done) seen_done++;
        n_checks++;
        if (q !== 3'd4 || busy !== 1'b0) begin
            $display("FAIL abort_state: got q=%0d busy=%b required q=4 busy=0",
                     q, busy);
            n_fail++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) seen_done++;
        end
        n_checks++;
        if (seen_done != 0 || q !== 3'd4) begin
            $display("FAIL abort_nodone: got done_cycles=%0d q=%0d required 0 and q=4",
                     seen_done, q);
            n_fail++;
        end
    endtask

    task automatic test_clear_midrun();
        do_clear();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 3'd3;
        tick();
        wr_en = 1'b0;
        start = 1'b1; step_num = 8'd3;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (q !== 3'd3) begin
            $display("FAIL clr_pre: got q=%0d required 3", q);
            n_fail++;
        end
        #2;
        clear = 1'b1;
        #1;
        n_checks++;
        if (q !== 3'd4 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL clr_async: got q=%0d busy=%b done=%b required q=4 busy=0 done=0",
                     q, busy, done);
            n_fail++;
        end
        #1;
        clear = 1'b0;
        start = 1'b1; step_num = 8'd1;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (q !== 3'd7 || done !== 1'b1) begin
            $display("FAIL clr_tbl_restored: got q=%0d done=%b required q=7 done=1",
                     q, done);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        start = 1'b1; step_num = 8'd2;
        tick();
        start = 1'b0;
        tick(); tick();
        tick();
        n_checks++;
        if (q !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL b2b_hold: got q=%0d done=%b busy=%b required q=0 done=0 busy=0",
                     q, done, busy);
            n_fail++;
        end
        start = 1'b1; step_num = 8'd1;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 3'd5;
        tick();
        start = 1'b0; wr_en = 1'b0;
        n_checks++;
        if (q !== 3'd4 || busy !== 1'b1) begin
            $display("FAIL b2b_restart: got q=%0d busy=%b required q=4 busy=1",
                     q, busy);
            n_fail++;
        end
        tick();
        n_checks++;
        if (q !== 3'd5 || done !== 1'b1) begin
            $display("FAIL b2b_newentry: got q=%0d done=%b required q=5 done=1",
                     q, done);
            n_fail++;
        end
        n_checks++;
        if (wrap_cnt !== 8'd0) begin
            $display("FAIL b2b_wrap: got %0d required 0", wrap_cnt);
            n_fail++;
        end
    endtask

    initial begin
        clear = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        step_num = 8'd0;
        wr_en = 1'b0;
        wr_addr = 3'd0;
        wr_data = 3'd0;
        test_reset();
        test_run5();
        test_pause();
        test_table_write();
        test_zero_steps();
        test_abort();
        test_clear_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
